aes_engine_sched: RTL and testbench

Round scheduler and two-port arbiter for a single shared iterative AES round engine, replacing the three parallel unrolled cipher instances used today. Grants the engine to either the encrypt requester or the decrypt requester, latches the key-length code (byte count 16/24/32, same encoding as the `param` byte carried in the SPI frame), and drives load, round-step and round-key-index controls for Nr = 10/12/14 rounds. It then returns a one-cycle done pulse to the winner.

---
 rtl/aes_engine_sched.sv | 200 ++++++++++++++++++++
 tb/tb_aes_engine_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_engine_sched.sv
`default_nettype none
// ============================================================================
//  Module   : aes_engine_sched
//  Purpose  : Arbiter and round scheduler sharing one iterative AES round
//             engine between an encrypt and a decrypt requester.
//  Revision : 1.0  initial release
// ============================================================================
module aes_engine_sched #(
    parameter int ROUND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_enc,
    input  logic [7:0] klen_enc,
    input  logic       req_dec,
    input  logic [7:0] klen_dec,
    output logic       gnt_enc,
    output logic       gnt_dec,
    output logic       done_enc,
    output logic       done_dec,
    output logic       err_enc,
    output logic       err_dec,
    output logic       busy,
    output logic       eng_dir,
    output logic [3:0] eng_nr,
    output logic       eng_load,
    output logic       eng_en,
    output logic       eng_last,
    output logic [3:0] eng_rk_idx
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_round = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_err   = 3'd4;

    localparam logic [3:0] c_rc_last = 4'(ROUND_CYCLES - 1);

    // Nr from key length in bytes; zero marks an illegal length.
    function automatic logic [3:0] f_nr(input logic [7:0] klen);
        case (klen)
            8'd16:   return 4'd10;
            8'd24:   return 4'd12;
            8'd32:   return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    logic [2:0] r_state, w_state;
    logic       r_prio, w_prio;
    logic       r_dir, w_dir;
    logic [3:0] r_nr, w_nr;
    logic [3:0] r_round, w_round;
    logic [3:0] r_cyc, w_cyc;
    logic       r_gnt_enc, w_gnt_enc, r_gnt_dec, w_gnt_dec;
    logic       r_done_enc, w_done_enc, r_done_dec, w_done_dec;
    logic       r_err_enc, w_err_enc, r_err_dec, w_err_dec;
    logic       r_busy, w_busy, r_load, w_load, r_en, w_en, r_last, w_last;
    logic [3:0] r_rk_idx, w_rk_idx;

    logic       w_pick_dec;
    logic [7:0] w_klen;
    logic       w_own_req;

    assign w_pick_dec = req_dec & (~req_enc | r_prio);
    assign w_klen     = w_pick_dec ? klen_dec : klen_enc;
    assign w_own_req  = r_dir ? req_dec : req_enc;

    always_comb begin
        w_state   = r_state;
        w_prio    = r_prio;
        w_dir     = r_dir;
        w_nr      = r_nr;
        w_round   = r_round;
        w_cyc     = r_cyc;
        w_gnt_enc = r_gnt_enc;
        w_gnt_dec = r_gnt_dec;

        case (r_state)
            c_st_idle: begin
                if (req_enc || req_dec) begin
                    w_dir     = w_pick_dec;
                    w_gnt_enc = ~w_pick_dec;
                    w_gnt_dec = w_pick_dec;
                    w_nr      = f_nr(w_klen);
                    w_state   = (w_nr != 4'd0) ? c_st_load : c_st_err;
                end
            end
            c_st_load: begin
                if (!w_own_req) begin
                    w_state = c_st_idle;
                end else begin
                    w_state = c_st_round;
                    w_round = 4'd1;
                    w_cyc   = 4'd0;
                end
            end
            c_st_round: begin
                if (!w_own_req) begin
                    w_state = c_st_idle;
                end else if (r_cyc == c_rc_last) begin
                    if (r_round == r_nr) begin
                        w_state = c_st_done;
                    end else begin
                        w_round = r_round + 4'd1;
                        w_cyc   = 4'd0;
                    end
                end else begin
                    w_cyc = r_cyc + 4'd1;
                end
            end
            c_st_done, c_st_err: begin
                w_state = c_st_idle;
                w_prio  = ~r_dir;
            end
            default: w_state = c_st_idle;
        endcase

        // Back in IDLE every engine-facing output returns to zero.
        if (w_state == c_st_idle) begin
            w_gnt_enc = 1'b0;
            w_gnt_dec = 1'b0;
            w_dir     = 1'b0;
            w_nr      = 4'd0;
        end

        // Outputs are registered, so decode them from the upcoming state.
        w_busy     = (w_state != c_st_idle);
        w_load     = (w_state == c_st_load);
        w_en       = (w_state == c_st_round) && (w_cyc == c_rc_last);
        w_last     = w_en && (w_round == w_nr);
        w_done_enc = (w_state == c_st_done) && !w_dir;
        w_done_dec = (w_state == c_st_done) && w_dir;
        w_err_enc  = (w_state == c_st_err) && !w_dir;
        w_err_dec  = (w_state == c_st_err) && w_dir;
        w_rk_idx   = 4'd0;
        if (w_state == c_st_load) begin
            w_rk_idx = w_dir ? w_nr : 4'd0;
        end else if (w_state == c_st_round) begin
            w_rk_idx = w_dir ? (w_nr - w_round) : w_round;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_prio     <= 1'b0;
            r_dir      <= 1'b0;
            r_nr       <= 4'd0;
            r_round    <= 4'd0;
            r_cyc      <= 4'd0;
            r_gnt_enc  <= 1'b0;
            r_gnt_dec  <= 1'b0;
            r_done_enc <= 1'b0;
            r_done_dec <= 1'b0;
            r_err_enc  <= 1'b0;
            r_err_dec  <= 1'b0;
            r_busy     <= 1'b0;
            r_load     <= 1'b0;
            r_en       <= 1'b0;
            r_last     <= 1'b0;
            r_rk_idx   <= 4'd0;
        end else begin
            r_state    <= w_state;
            r_prio     <= w_prio;
            r_dir      <= w_dir;
            r_nr       <= w_nr;
            r_round    <= w_round;
            r_cyc      <= w_cyc;
            r_gnt_enc  <= w_gnt_enc;
            r_gnt_dec  <= w_gnt_dec;
            r_done_enc <= w_done_enc;
            r_done_dec <= w_done_dec;
            r_err_enc  <= w_err_enc;
            r_err_dec  <= w_err_dec;
            r_busy     <= w_busy;
            r_load     <= w_load;
            r_en       <= w_en;
            r_last     <= w_last;
            r_rk_idx   <= w_rk_idx;
        end
    end

    assign gnt_enc    = r_gnt_enc;
    assign gnt_dec    = r_gnt_dec;
    assign done_enc   = r_done_enc;
    assign done_dec   = r_done_dec;
    assign err_enc    = r_err_enc;
    assign err_dec    = r_err_dec;
    assign busy       = r_busy;
    assign eng_dir    = r_dir;
    assign eng_nr     = r_nr;
    assign eng_load   = r_load;
    assign eng_en     = r_en;
    assign eng_last   = r_last;
    assign eng_rk_idx = r_rk_idx;

endmodule
`default_nettype wire

// File: tb/tb_aes_engine_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_engine_sched
//  Purpose  : Scoreboard bench for aes_engine_sched, ROUND_CYCLES 1 and 3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_engine_sched;

    localparam int RC0 = 1;
    localparam int RC1 = 3;

    typedef struct {
        int       cyc;
        int       kind;   // 0 load, 1 round, 2 done, 3 err
        bit       dir;
        bit [3:0] rk;
        bit       last;
        bit [3:0] nr;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_enc, req_dec, gnt_enc, gnt_dec, done_enc, done_dec;
    logic [1:0] err_enc, err_dec, busy, eng_dir, eng_load, eng_en, eng_last;
    logic [7:0] klen_enc [2];
    logic [7:0] klen_dec [2];
    logic [3:0] eng_nr [2];
    logic [3:0] eng_rk_idx [2];

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  prio [2];
    ev_t q0 [$];
    ev_t q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_engine_sched #(.ROUND_CYCLES(RC0)) u_dut_rc1 (
        .clk(clk), .reset(reset),
        .req_enc(req_enc[0]), .klen_enc(klen_enc[0]),
        .req_dec(req_dec[0]), .klen_dec(klen_dec[0]),
        .gnt_enc(gnt_enc[0]), .gnt_dec(gnt_dec[0]),
        .done_enc(done_enc[0]), .done_dec(done_dec[0]),
        .err_enc(err_enc[0]), .err_dec(err_dec[0]),
        .busy(busy[0]), .eng_dir(eng_dir[0]), .eng_nr(eng_nr[0]),
        .eng_load(eng_load[0]), .eng_en(eng_en[0]), .eng_last(eng_last[0]),
        .eng_rk_idx(eng_rk_idx[0])
    );

    aes_engine_sched #(.ROUND_CYCLES(RC1)) u_dut_rc3 (
        .clk(clk), .reset(reset),
        .req_enc(req_enc[1]), .klen_enc(klen_enc[1]),
        .req_dec(req_dec[1]), .klen_dec(klen_dec[1]),
        .gnt_enc(gnt_enc[1]), .gnt_dec(gnt_dec[1]),
        .done_enc(done_enc[1]), .done_dec(done_dec[1]),
        .err_enc(err_enc[1]), .err_dec(err_dec[1]),
        .busy(busy[1]), .eng_dir(eng_dir[1]), .eng_nr(eng_nr[1]),
        .eng_load(eng_load[1]), .eng_en(eng_en[1]), .eng_last(eng_last[1]),
        .eng_rk_idx(eng_rk_idx[1])
    );

    function automatic int rc_of(int i);
        return (i == 0) ? RC0 : RC1;
    endfunction

    function automatic int nr_of(int klen);
        case (klen)
            16:      return 10;
            24:      return 12;
            32:      return 14;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] pick_klen(bit legal_only);
        int s;
        s = $urandom_range(0, legal_only ? 2 : 3);
        case (s)
            0:       return 8'd16;
            1:       return 8'd24;
            2:       return 8'd32;
            default: return ($urandom_range(0, 1) == 0) ? 8'd20 : 8'($urandom_range(33, 255));
        endcase
    endfunction

    task automatic push(int i, int c, int kind, bit dir, int rk, bit last, int nr);
        ev_t e;
        e.cyc = c; e.kind = kind; e.dir = dir;
        e.rk = 4'(rk); e.last = last; e.nr = 4'(nr);
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    function automatic ev_t qpop(int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // Expected schedule of one granted job whose request is sampled at edge t.
    task automatic push_job(int i, bit dec, int klen, int t, output int e_cyc);
        int nr;
        int rc;
        nr = nr_of(klen);
        rc = rc_of(i);
        if (nr == 0) begin
            push(i, t + 1, 3, dec, 0, 1'b0, 0);
            e_cyc = t + 1;
        end else begin
            push(i, t + 1, 0, dec, dec ? nr : 0, 1'b0, nr);
            for (int r = 1; r <= nr; r++)
                push(i, t + 1 + r * rc, 1, dec, dec ? nr - r : r, r == nr, nr);
            e_cyc = t + 2 + nr * rc;
            push(i, e_cyc, 2, dec, 0, 1'b0, 0);
        end
        prio[i] = !dec;
    endtask

    task automatic check_zero(int i, string name);
        logic [21:0] v;
        v = {gnt_enc[i], gnt_dec[i], done_enc[i], done_dec[i], err_enc[i], err_dec[i],
             busy[i], eng_dir[i], eng_load[i], eng_en[i], eng_last[i], eng_nr[i], eng_rk_idx[i]};
        vectors++;
        if (v !== '0) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: outputs %b, required all zero", name, i, cyc + 1, v);
        end
    endtask

    // Called at a negedge with requests already driven; serves up to n grants.
    task automatic serve(int i, int n, bit hold);
        for (int j = 0; j < n; j++) begin
            bit dec;
            int t;
            int e;
            if (!(req_enc[i] || req_dec[i])) break;
            t   = cyc + 1;
            dec = req_dec[i] && (!req_enc[i] || prio[i]);
            push_job(i, dec, dec ? int'(klen_dec[i]) : int'(klen_enc[i]), t, e);
            @(negedge clk);
            if (!hold && $urandom_range(0, 1) == 1) begin
                if (dec) klen_dec[i] = 8'($urandom_range(0, 255));
                else     klen_enc[i] = 8'($urandom_range(0, 255));
            end
            while (cyc + 1 < e) @(negedge clk);
            if (j == n - 1) begin
                req_enc[i] = 1'b0;
                req_dec[i] = 1'b0;
            end else if (!hold) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (dec) req_dec[i] = 1'b0; else req_enc[i] = 1'b0;
                end
                if (!req_enc[i] && $urandom_range(0, 1) == 1) begin
                    req_enc[i] = 1'b1; klen_enc[i] = pick_klen(1'b0);
                end
                if (!req_dec[i] && $urandom_range(0, 1) == 1) begin
                    req_dec[i] = 1'b1; klen_dec[i] = pick_klen(1'b0);
                end
            end
            @(negedge clk);
            vectors++;
            if (busy[i] || gnt_enc[i] || gnt_dec[i]) begin
                miscompares++;
                $display("FAIL idle_gap inst%0d cycle %0d: busy %b gnt %b%b, required 0 00",
                         i, cyc + 1, busy[i], gnt_enc[i], gnt_dec[i]);
            end
        end
        req_enc[i] = 1'b0;
        req_dec[i] = 1'b0;
    endtask

    // One normal encrypt job, then an encrypt job cut off in round 5 by
    // dropping the request or pulsing reset; then both ports compete.
    task automatic abort_job(int i, bit use_rst);
        int t;
        int nr;
        int c;
        @(negedge clk);
        req_enc[i] = 1'b1; klen_enc[i] = pick_klen(1'b1); req_dec[i] = 1'b0;
        serve(i, 1, 1'b1);
        @(negedge clk);
        req_enc[i] = 1'b1; klen_enc[i] = pick_klen(1'b1);
        t  = cyc + 1;
        nr = nr_of(int'(klen_enc[i]));
        c  = t + 1 + 5 * rc_of(i);
        push(i, t + 1, 0, 1'b0, 0, 1'b0, nr);
        for (int r = 1; r <= 5; r++) push(i, t + 1 + r * rc_of(i), 1, 1'b0, r, 1'b0, nr);
        @(negedge clk);
        while (cyc + 1 < c) @(negedge clk);
        req_enc[i] = 1'b0;
        if (use_rst) reset = 1'b1;
        @(negedge clk);
        check_zero(i, use_rst ? "reset_mid_round" : "abort_mid_round");
        reset = 1'b0;
        if (use_rst) begin prio[0] = 1'b0; prio[1] = 1'b0; end
        req_enc[i] = 1'b1; klen_enc[i] = pick_klen(1'b1);
        req_dec[i] = 1'b1; klen_dec[i] = pick_klen(1'b1);
        serve(i, 1, 1'b1);
    endtask

    // Monitor: every engine/done/err pulse is matched against the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  npulse;
            bit  ok;
            ev_t got;
            ev_t want;
            npulse = int'(eng_load[i]) + int'(eng_en[i]) + int'(done_enc[i]) + int'(done_dec[i])
                   + int'(err_enc[i]) + int'(err_dec[i]);
            if (npulse != 0 || eng_last[i]) begin
                got.cyc  = cyc + 1;
                got.kind = eng_load[i] ? 0 : eng_en[i] ? 1 : (done_enc[i] || done_dec[i]) ? 2
                         : (err_enc[i] || err_dec[i]) ? 3 : 4;
                got.dir  = (got.kind >= 2) ? (done_dec[i] | err_dec[i]) : eng_dir[i];
                got.rk   = eng_rk_idx[i];
                got.last = eng_last[i];
                got.nr   = eng_nr[i];
                vectors++;
                if (qsize(i) == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event inst%0d cycle %0d: kind %0d dir %0d rk %0d, required no event",
                             i, got.cyc, got.kind, got.dir, got.rk);
                end else begin
                    want = qpop(i);
                    ok = (npulse == 1) && (got.cyc == want.cyc) && (got.kind == want.kind)
                         && (got.dir == want.dir) && busy[i];
                    if (want.kind <= 1)
                        ok = ok && (got.rk == want.rk) && (got.last == want.last) && (got.nr == want.nr)
                             && (gnt_enc[i] == !want.dir) && (gnt_dec[i] == want.dir);
                    else
                        ok = ok && !eng_last[i];
                    if (!ok) begin
                        miscompares++;
                        $display("FAIL event inst%0d: got cyc %0d kind %0d dir %0d rk %0d last %0d nr %0d pulses %0d busy %0d gnt %b%b; required cyc %0d kind %0d dir %0d rk %0d last %0d nr %0d",
                                 i, got.cyc, got.kind, got.dir, got.rk, got.last, got.nr, npulse, busy[i],
                                 gnt_enc[i], gnt_dec[i], want.cyc, want.kind, want.dir, want.rk, want.last, want.nr);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req_enc = '0; req_dec = '0;
        for (int i = 0; i < 2; i++) begin klen_enc[i] = 8'd0; klen_dec[i] = 8'd0; prio[i] = 1'b0; end
        repeat (3) @(negedge clk);
        check_zero(0, "reset_state");
        check_zero(1, "reset_state");
        reset = 1'b0;

        // Encrypt 16-byte key, then decrypt 32-byte key.
        @(negedge clk); req_enc[0] = 1'b1; klen_enc[0] = 8'd16; serve(0, 1, 1'b1);
        @(negedge clk); req_dec[0] = 1'b1; klen_dec[0] = 8'd32; serve(0, 1, 1'b1);

        // Both held with 24-byte keys: grants alternate.
        @(negedge clk);
        req_enc[0] = 1'b1; klen_enc[0] = 8'd24; req_dec[0] = 1'b1; klen_dec[0] = 8'd24;
        serve(0, 4, 1'b1);

        // Illegal encrypt length with decrypt pending.
        @(negedge clk);
        req_enc[0] = 1'b1; klen_enc[0] = 8'd20; req_dec[0] = 1'b1; klen_dec[0] = 8'd16;
        serve(0, 2, 1'b1);

        // Multi-cycle rounds.
        @(negedge clk); req_enc[1] = 1'b1; klen_enc[1] = 8'd16; serve(1, 1, 1'b1);
        @(negedge clk); req_dec[1] = 1'b1; klen_dec[1] = 8'd24; serve(1, 1, 1'b1);

        abort_job(0, 1'b0);
        abort_job(0, 1'b1);
        abort_job(1, 1'b0);

        for (int s = 0; s < 24; s++) begin
            int i;
            i = (s % 4 == 3) ? 1 : 0;
            @(negedge clk);
            req_enc[i] = 1'($urandom_range(0, 1));
            req_dec[i] = 1'($urandom_range(0, 1));
            if (!req_enc[i] && !req_dec[i]) req_enc[i] = 1'b1;
            klen_enc[i] = pick_klen(1'b0);
            klen_dec[i] = pick_klen(1'b0);
            serve(i, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (qsize(i) != 0) begin
                miscompares++;
                $display("FAIL missing_events inst%0d: %0d expected events never seen, required 0", i, qsize(i));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
